// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: MII receive front end. Strips preamble/SFD,
// assembles bytes, checks CRC-32 and length, forwards DA..payload.
// Ports: clk, rst (sync, active high); eth_rxdv, eth_rx_data[3:0] MII in;
//   rec_en/rec_data[7:0] byte strobe; rec_pkt_done end-of-frame strobe;
//   rec_good, crc_err, len_err, rec_byte_num[15:0] held frame verdict.
// Optional: define RX_ADDR_FILTER_EN to drop frames whose DA is neither
//   BOARD_MAC nor broadcast (delay line then 6 bytes deep).

module eth_rx_fcs_check #(
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter logic [47:0] BOARD_MAC     = 48'h00_11_22_33_44_55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eth_rxdv,
    input  logic [3:0]  eth_rx_data,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_pkt_done,
    output logic        rec_good,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] rec_byte_num
);

`ifdef RX_ADDR_FILTER_EN
    localparam int DL_DEPTH = 6;
`else
    localparam int DL_DEPTH = 4;
`endif

    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] DL_LEN      = 16'(DL_DEPTH);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        S_DROP,
        S_IDLE,
        S_PRE,
        S_DATA,
        S_END
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  pre_cnt;
    logic        hi_phase;
    logic [3:0]  low_nib;
    logic [31:0] crc;
    logic [15:0] byte_cnt;
    logic [7:0]  dline [DL_DEPTH];
    logic        oversize;
    logic        addr_ok;

    logic        frame_start;
    logic        nib_take;
    logic        byte_done;
    logic        frame_end;
    logic [7:0]  byte_in;
    logic        fwd_ok;
    logic        crc_bad;
    logic        len_bad;
    logic        report;

    // Reflected CRC-32, one nibble LSB first.
    function automatic logic [31:0] crc_nib(
        input logic [31:0] c,
        input logic [3:0]  d
    );
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DROP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_DROP: begin
                if (!eth_rxdv) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (eth_rxdv) begin
                    state_nxt = (eth_rx_data == 4'h5) ? S_PRE : S_DROP;
                end
            end
            S_PRE: begin
                if (!eth_rxdv) begin
                    state_nxt = S_DROP;
                end else if (eth_rx_data == 4'h5) begin
                    state_nxt = S_PRE;
                end else if (eth_rx_data == 4'hD && pre_cnt == 2'd2) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!eth_rxdv) state_nxt = S_END;
            end
            S_END: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_DROP;
            end
        endcase
    end

    always_comb begin
        frame_start = (state == S_PRE) && (state_nxt == S_DATA);
        nib_take    = (state == S_DATA) && eth_rxdv;
        byte_done   = nib_take && hi_phase;
        frame_end   = (state == S_DATA) && !eth_rxdv;
        byte_in     = {eth_rx_data, low_nib};
        // Byte N releases byte N-DL_DEPTH; stop once past the max length.
        fwd_ok      = byte_done && addr_ok && !oversize &&
                      (byte_cnt >= DL_LEN) && (byte_cnt < MAX_LEN);
        // A dangling half byte always counts as a CRC failure.
        crc_bad     = (crc != CRC_RESIDUE) || hi_phase;
        len_bad     = (byte_cnt < MIN_LEN) || (byte_cnt > MAX_LEN);
`ifdef RX_ADDR_FILTER_EN
        report      = frame_end && addr_ok && (byte_cnt >= 16'd6);
`else
        report      = frame_end && addr_ok;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= 2'd0;
            hi_phase     <= 1'b0;
            low_nib      <= 4'd0;
            crc          <= CRC_INIT;
            byte_cnt     <= 16'd0;
            oversize     <= 1'b0;
            for (int i = 0; i < DL_DEPTH; i++) dline[i] <= 8'd0;
            rec_en       <= 1'b0;
            rec_data     <= 8'd0;
            rec_pkt_done <= 1'b0;
            rec_good     <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            rec_byte_num <= 16'd0;
        end else begin
            rec_en       <= 1'b0;
            rec_pkt_done <= 1'b0;

            if (state == S_IDLE) begin
                pre_cnt <= 2'd1;
            end else if (state == S_PRE && eth_rx_data == 4'h5 &&
                         pre_cnt != 2'd2) begin
                pre_cnt <= pre_cnt + 2'd1;
            end

            if (frame_start) begin
                crc      <= CRC_INIT;
                byte_cnt <= 16'd0;
                hi_phase <= 1'b0;
                oversize <= 1'b0;
            end

            if (nib_take) begin
                crc      <= crc_nib(crc, eth_rx_data);
                hi_phase <= !hi_phase;
                if (!hi_phase) low_nib <= eth_rx_data;
            end

            if (byte_done) begin
                dline[0] <= byte_in;
                for (int i = 1; i < DL_DEPTH; i++) dline[i] <= dline[i-1];
                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                if (byte_cnt >= MAX_LEN) oversize <= 1'b1;
            end

            if (fwd_ok) begin
                rec_en   <= 1'b1;
                rec_data <= dline[DL_DEPTH-1];
            end

            if (report) begin
                rec_pkt_done <= 1'b1;
                crc_err      <= crc_bad;
                len_err      <= len_bad;
                rec_good     <= !crc_bad && !len_bad;
                rec_byte_num <= (byte_cnt >= 16'd4) ? byte_cnt - 16'd4 : 16'd0;
            end
        end
    end

`ifdef RX_ADDR_FILTER_EN
    logic       mac_ok;
    logic       bc_ok;
    logic [7:0] mac_b [8];

    // DA byte 0 is the most significant byte of BOARD_MAC.
    always_comb begin
        mac_b = '{default: 8'h00};
        for (int i = 0; i < 6; i++) mac_b[i] = BOARD_MAC[8*(5-i) +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_ok <= 1'b1;
            bc_ok  <= 1'b1;
        end else if (frame_start) begin
            mac_ok <= 1'b1;
            bc_ok  <= 1'b1;
        end else if (byte_done && byte_cnt < 16'd6) begin
            mac_ok <= mac_ok && (byte_in == mac_b[byte_cnt[2:0]]);
            bc_ok  <= bc_ok && (byte_in == 8'hFF);
        end
    end

    assign addr_ok = mac_ok || bc_ok;
`else
    logic unused_mac;
    assign unused_mac = ^BOARD_MAC;
    assign addr_ok    = 1'b1;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: randomized self-checking bench for eth_rx_fcs_check.
// Frames are built as byte queues; a frame-level model predicts strobes/verdicts.

module tb_eth_rx_fcs_check;

    typedef logic [7:0] bq_t [$];
    typedef logic [3:0] nq_t [$];

`ifdef RX_ADDR_FILTER_EN
    localparam bit FILT  = 1'b1;
    localparam int DEPTH = 6;
`else
    localparam bit FILT  = 1'b0;
    localparam int DEPTH = 4;
`endif
    localparam logic [47:0] MAC  = 48'h00_11_22_33_44_55;
    localparam int          MINL = 64;
    localparam int          MAXL = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eth_rxdv = 1'b0;
    logic [3:0]  eth_rx_data = 4'd0;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic        rec_good;
    logic        crc_err;
    logic        len_err;
    logic [15:0] rec_byte_num;

    always #5 clk = ~clk;

    eth_rx_fcs_check #(
        .MIN_FRAME_LEN(MINL),
        .MAX_FRAME_LEN(MAXL),
        .BOARD_MAC(MAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eth_rxdv(eth_rxdv),
        .eth_rx_data(eth_rx_data),
        .rec_en(rec_en),
        .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done),
        .rec_good(rec_good),
        .crc_err(crc_err),
        .len_err(len_err),
        .rec_byte_num(rec_byte_num)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got_d [$];
    logic [7:0]  exp_d [$];
    logic [18:0] got_s [$];
    logic [18:0] exp_s [$];
    bit          prev_en = 1'b0;

    always @(negedge clk) begin
        if (rec_en === 1'b1) begin
            got_d.push_back(rec_data);
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL rec_en_back_to_back got 1 exp 0");
            end
        end
        if (rec_pkt_done === 1'b1)
            got_s.push_back({rec_good, crc_err, len_err, rec_byte_num});
        prev_en = (rec_en === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [31:0] crc32(input bq_t q);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c ^= {24'd0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t q = p;
        logic [31:0] f = crc32(p);
        for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
        return q;
    endfunction

    function automatic bq_t seq(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        return q;
    endfunction

    function automatic bq_t rnd(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic nq_t to_nibs(input bq_t f, input bit odd, input bit bad_pre);
        nq_t n;
        if (bad_pre) begin
            n.push_back(4'h5); n.push_back(4'h5);
            n.push_back(4'hA); n.push_back(4'h5);
            repeat (6) begin n.push_back(4'h5); n.push_back(4'h5); end
        end else begin
            repeat (7) begin n.push_back(4'h5); n.push_back(4'h5); end
        end
        n.push_back(4'h5);
        n.push_back(4'hD);
        foreach (f[i]) begin
            n.push_back(f[i][3:0]);
            n.push_back(f[i][7:4]);
        end
        if (odd) n.push_back(4'($urandom_range(0, 15)));
        return n;
    endfunction

    // Frame-level expectation: forwarded bytes and the verdict record.
    function automatic void model(input bq_t f, input bit odd);
        int          total = f.size();
        bit          keep = 1'b1;
        int          nf;
        bq_t         body;
        logic [31:0] fcs;
        bit          ce, le;
        if (FILT) begin
            keep = (total >= 6);
            if (keep) begin
                logic [47:0] da = {f[0], f[1], f[2], f[3], f[4], f[5]};
                keep = (da == MAC) || (da == 48'hFFFF_FFFF_FFFF);
            end
        end
        if (!keep) return;
        nf = ((total < MAXL) ? total : MAXL) - DEPTH;
        for (int i = 0; i < nf; i++) exp_d.push_back(f[i]);
        for (int i = 0; i < total - 4; i++) body.push_back(f[i]);
        fcs = {f[total-1], f[total-2], f[total-3], f[total-4]};
        ce = (crc32(body) != fcs) || odd;
        le = (total < MINL) || (total > MAXL);
        exp_s.push_back({!ce && !le, ce, le, 16'(total - 4)});
    endfunction

    task automatic clear_q();
        got_d.delete(); exp_d.delete();
        got_s.delete(); exp_s.delete();
    endtask

    task automatic drive(input nq_t n);
        foreach (n[i]) begin
            @(negedge clk);
            eth_rxdv = 1'b1;
            eth_rx_data = n[i];
        end
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(negedge clk);
            eth_rxdv = 1'b0;
            eth_rx_data = 4'd0;
        end
    endtask

    task automatic test_reset();
        clear_q();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            eth_rxdv = 1'b1;
            eth_rx_data = 4'h5;
        end
        checks++;
        if ({rec_en, rec_pkt_done, rec_good, crc_err, len_err, rec_data,
             rec_byte_num} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {rec_en, rec_pkt_done,
                     rec_good, crc_err, len_err, rec_data, rec_byte_num});
        end
        @(negedge clk);
        rst = 1'b0;
        drive(to_nibs(with_fcs(seq(60)), 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != 0 || got_s.size() != 0) begin
            errors++;
            $display("FAIL reset_inflight got %0d/%0d exp 0/0", got_d.size(), got_s.size());
        end
    endtask

    task automatic test_good_frame();
        bq_t f;
        clear_q();
        f = with_fcs(seq(60));
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL good_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL good_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL good_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL good_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_crc_error();
        bq_t f;
        clear_q();
        f = with_fcs(seq(60));
        f[10] = 8'hFF;
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL crc_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL crc_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL crc_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL crc_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_rst_mid_frame();
        bq_t f;
        nq_t n;
        clear_q();
        n = to_nibs(with_fcs(seq(60)), 1'b0, 1'b0);
        // Nibble 56 is the low nibble of payload byte 20.
        for (int i = 0; i < n.size(); i++) begin
            @(negedge clk);
            if (i == 57) begin
                checks++;
                if ({rec_en, rec_pkt_done, rec_good, crc_err, len_err, rec_data,
                     rec_byte_num} !== 29'd0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs got %h exp 0", {rec_en,
                             rec_pkt_done, rec_good, crc_err, len_err, rec_data,
                             rec_byte_num});
                end
            end
            eth_rxdv = 1'b1;
            eth_rx_data = n[i];
            rst = (i == 56);
        end
        idle(4);
        checks++;
        if (got_s.size() != 0 || got_d.size() != (FILT ? 0 : 16)) begin
            errors++;
            $display("FAIL rst_mid_ignored got %0d/%0d exp 0/%0d", got_s.size(),
                     got_d.size(), FILT ? 0 : 16);
        end
        clear_q();
        f = with_fcs(rnd(70));
        f[0] = 8'hFF; f[1] = 8'hFF; f[2] = 8'hFF;
        f = with_fcs(f[0:69]);
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL rst_next_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL rst_next_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL rst_next_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL rst_next_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_length();
        bq_t f;
        clear_q();
        f = with_fcs(seq(40));
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(3);
        f = with_fcs(seq(0));
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(3);
        f = with_fcs(rnd(1596));
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL len_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL len_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL len_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL len_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_odd_nibble();
        bq_t f;
        clear_q();
        f = with_fcs(seq(60));
        model(f, 1'b1);
        drive(to_nibs(f, 1'b1, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL odd_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL odd_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL odd_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL odd_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_bad_preamble();
        bq_t f;
        clear_q();
        f = with_fcs(seq(60));
        drive(to_nibs(f, 1'b0, 1'b1));
        idle(3);
        f = with_fcs(rnd(64));
        model(f, 1'b0);
        drive(to_nibs(f, 1'b0, 1'b0));
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL pre_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL pre_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL pre_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL pre_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

    task automatic test_back_to_back();
        bq_t p;
        bq_t f;
        bit  odd;
        clear_q();
        for (int k = 0; k < 6; k++) begin
            p = rnd($urandom_range(40, 120));
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < 6; i++) p[i] = MAC[8*(5-i) +: 8];
            f = with_fcs(p);
            if ($urandom_range(0, 2) == 0)
                f[$urandom_range(0, f.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            odd = ($urandom_range(0, 3) == 0);
            model(f, odd);
            drive(to_nibs(f, odd, 1'b0));
            idle($urandom_range(1, 3));
        end
        idle(4);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL b2b_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL b2b_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL b2b_done_cnt got %0d exp %0d", got_s.size(), exp_s.size());
        end else for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL b2b_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
    endtask

`ifdef RX_ADDR_FILTER_EN
    task automatic test_addr_filter();
        bq_t         p;
        logic [47:0] das [3];
        das[0] = 48'h00_11_22_33_44_56;
        das[1] = 48'hFF_FF_FF_FF_FF_FF;
        das[2] = MAC;
        clear_q();
        for (int k = 0; k < 3; k++) begin
            p = seq(60);
            for (int i = 0; i < 6; i++) p[i] = das[k][8*(5-i) +: 8];
            model(with_fcs(p), 1'b0);
            drive(to_nibs(with_fcs(p), 1'b0, 1'b0));
            idle(3);
        end
        idle(2);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++;
            $display("FAIL filt_fwd_cnt got %0d exp %0d", got_d.size(), exp_d.size());
        end else for (int i = 0; i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL filt_fwd[%0d] got %h exp %h", i, got_d[i], exp_d[i]);
            break;
        end
        checks++;
        if (got_s.size() != 2) begin
            errors++;
            $display("FAIL filt_done_cnt got %0d exp 2", got_s.size());
        end else for (int i = 0; i < 2; i++) if (got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL filt_status[%0d] got %h exp %h", i, got_s[i], exp_s[i]);
            break;
        end
        checks++;
        if (rec_good !== 1'b1) begin
            errors++;
            $display("FAIL filt_good got %b exp 1", rec_good);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_rst_mid_frame();
        test_length();
        test_odd_nibble();
        test_bad_preamble();
        test_back_to_back();
`ifdef RX_ADDR_FILTER_EN
        test_addr_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- MII receive-side front end for the Ethernet/UDP stack, mirroring the CRC-appending transmit path.
- Consumes raw 4-bit MII nibbles and strips preamble/SFD.
- Assembles bytes and computes CRC-32 over the frame.
- Forwards the frame bytes minus the 4-byte FCS, then reports a per-frame good/CRC-error/length-error verdict for the IP/UDP parser downstream.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_FRAME_LEN, 1518, maximum legal frame length in bytes (DA through FCS).
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC address; used only when RX_ADDR_FILTER_EN is defined.

Ports:
- clk, input, 1, MII receive clock; single clock domain.
- rst, input, 1, synchronous active-high reset.
- eth_rxdv, input, 1, MII receive data valid.
- eth_rx_data, input, 4, MII receive nibble, low nibble of each byte first.
- rec_en, output, 1, one-cycle strobe: rec_data valid.
- rec_data, output, 8, forwarded frame byte (DA onward, FCS excluded).
- rec_pkt_done, output, 1, one-cycle end-of-frame strobe.
- rec_good, output, 1, frame verdict; valid from rec_pkt_done, held until next rec_pkt_done.
- crc_err, output, 1, FCS mismatch or odd nibble count; held like rec_good.
- len_err, output, 1, length outside MIN/MAX; held like rec_good.
- rec_byte_num, output, 16, forwarded byte count (total length minus 4); held like rec_good.

Behaviour:
- Reset: every output 0; state DROP; CRC register 0xFFFFFFFF; byte counter 0; delay line cleared.
- All inputs are sampled on the rising edge of clk.
- States:
  - DROP: wait for eth_rxdv=0, then go to IDLE. Reset lands here, so a frame already in progress at reset is ignored.
  - IDLE: on eth_rxdv=1 with nibble 0x5, go to PREAMBLE. On eth_rxdv=1 with any other nibble, go to DROP (no done pulse).
  - PREAMBLE: nibble 0x5 stays in PREAMBLE. Nibble 0xD after at least 2 consecutive 0x5 nibbles goes to DATA. Any other nibble, or eth_rxdv=0, goes to DROP (no done pulse).
  - DATA:
    - Nibble pairs form bytes as {high, low}.
    - Each nibble feeds the reflected CRC-32 (poly 0x04C11DB7, LSB first, init 0xFFFFFFFF). FCS nibbles are included.
    - Byte counter increments on every completed byte and saturates at 0xFFFF.
    - When eth_rxdv=0 is sampled, go to END.
  - END (one cycle):
    - Assert rec_pkt_done and update the status outputs.
    - crc_err = 1 when the CRC register is not 0xDEBB20E3, or when the nibble count is odd.
    - len_err = 1 when the byte count is < MIN_FRAME_LEN or > MAX_FRAME_LEN.
    - rec_good = !crc_err && !len_err.
    - Go to IDLE.
- Delay line: 4-byte shift buffer.
  - When byte N (N>=4) completes, byte N-4 is presented with rec_en=1 on the next cycle.
  - The last 4 bytes (FCS) are never forwarded.
  - Latency: 1 clk after the high nibble of byte N is sampled.
  - rec_en is never asserted in two consecutive cycles.
- Frames shorter than 5 bytes produce no rec_en. They still produce rec_pkt_done with len_err=1, and rec_byte_num = max(count-4, 0).
- Oversize frames:
  - Once the count exceeds MAX_FRAME_LEN, stop forwarding and raise an internal error flag.
  - Keep counting until eth_rxdv=0, then END with len_err=1.
- Odd trailing nibble: discarded (not forwarded, not counted) and forces crc_err=1.
- rec_data holds its last value between strobes.
- rst mid-frame overrides everything in the next cycle: outputs go to 0, state goes to DROP.

Optional Feature:
RX_ADDR_FILTER_EN
- Defined:
  - Delay line deepens to 6 bytes; latency becomes byte N -> byte N-6, still 1 clk after completion.
  - The 6-byte DA is compared to BOARD_MAC and to FF:FF:FF:FF:FF:FF.
  - A mismatching frame is discarded silently: no rec_en, no rec_pkt_done, status outputs unchanged.
  - Frames under 6 bytes are also discarded silently.
  - FCS bytes are still excluded from forwarding.
- Undefined: no address check; 4-byte delay line; all frames reported.

Test Plan:
- 7x 0x55 + 0xD5 preamble, 60-byte payload 0x00..0x3B, correct FCS from bench model -> 60 rec_en strobes with data 0x00..0x3B in order; rec_pkt_done once; rec_good=1, crc_err=0, len_err=0, rec_byte_num=60.
- Same frame with payload byte 10 flipped to 0xFF -> 60 strobes, byte 10 = 0xFF; rec_good=0, crc_err=1, len_err=0.
- 40-byte payload frame with correct FCS (44 bytes total) -> 40 strobes; len_err=1, crc_err=0, rec_byte_num=40. Also a 1600-byte frame -> len_err=1, forwarding stops after 1518 bytes.
- Preamble 0x55 then 0x5A, followed by the rest of a valid frame -> no rec_en, no rec_pkt_done. A following valid frame is then received correctly.
- Assert rst for 1 cycle at payload byte 20 -> all outputs 0 next cycle; remainder of frame ignored, no rec_pkt_done; next frame received correctly.
- With RX_ADDR_FILTER_EN, BOARD_MAC=00:11:22:33:44:55:
  - DA 00:11:22:33:44:56 -> no strobes, no done.
  - DA FF:FF:FF:FF:FF:FF -> forwarded, rec_good=1.
  - DA = BOARD_MAC -> forwarded, rec_good=1.
